uart_cmd_controller: RTL and testbench
======================================

// Module: uart_cmd_controller
// PURPOSE
// - Sequences the UART receive path. Consumes frame/frame_valid from the UART frame processor and assembles 5-byte command packets.
// - Owns and drives the receiver's live configuration (parity, parity_type, stop_bits, frame_length).
// - Issues register writes to the VGA register file over a valid/ready handshake.
// - Packet format: SYNC, CMD, ARG1, ARG2, CHK. CHK = CMD ^ ARG1 ^ ARG2.
// PARAMETERS
// SYNC_BYTE        8'hA5  packet start marker (recognised only in HUNT)
// TIMEOUT_TICKS    704    max clk_16bd ticks between frames inside a packet (4 frame times at 11 bits)
// DEF_PARITY       1'b0   reset value of parity
// DEF_PARITY_TYPE  1'b0   reset value of parity_type (0 even, 1 odd)
// DEF_STOP_BITS    1'b0   reset value of stop_bits (0 one, 1 two)
// DEF_FRAME_LENGTH 4'd8   reset value of frame_length
// PORTS
// clk_16bd     in   1  16x baud clock, rising edge
// rst          in   1  reset, asynchronous, active-high
// frame        in   9  received frame; only [7:0] used, [8] ignored
// frame_valid  in   1  one-cycle strobe, frame stable in the same cycle
// parity       out  1  receiver config: parity enable
// parity_type  out  1  receiver config: parity type
// stop_bits    out  1  receiver config: stop-bit count select
// frame_length out  4  receiver config: data bits per frame
// reg_addr     out  8  VGA register address (ARG1)
// reg_data     out  8  VGA register data (ARG2)
// reg_valid    out  1  write request; held with addr/data until reg_ready
// reg_ready    in   1  VGA side accepts the write when reg_valid & reg_ready
// cmd_done     out  1  one-cycle pulse: packet executed successfully
// cmd_error    out  1  one-cycle pulse: packet or byte rejected
// err_code     out  3  valid with cmd_error; holds its last value otherwise
// busy         out  1  1 in any state other than HUNT
// BEHAVIOUR
// - Reset values: config outputs = DEF_* parameters; reg_addr/reg_data = 0; reg_valid, cmd_done, cmd_error, busy = 0; err_code = 0; state = HUNT. Reset mid-packet or mid-handshake drops the transaction and restores the default config.
// - States:
//   - HUNT: frame == SYNC_BYTE -> CMD; other bytes discarded with no error.
//   - CMD: opcode 8'h01 (WRITE_REG) or 8'h02 (SET_CFG) -> ARG1. Any other value -> cmd_error, ERR_CMD (3'd2) -> HUNT.
//   - ARG1 -> ARG2 -> CHK, one frame each. Each byte is latched.
//   - CHK, mismatch: cmd_error, ERR_CHK (3'd1) -> HUNT.
//   - CHK, match, SET_CFG: ARG1 maps to parity=[0], parity_type=[1], stop_bits=[2], frame_length=[7:4].
//     - frame_length must be 8 or 9; otherwise cmd_error, ERR_ARG (3'd5), config unchanged.
//     - Valid: all four config outputs update together in the cycle after the CHK strobe; cmd_done pulses the same cycle -> HUNT. ARG2 ignored.
//   - CHK, match, WRITE_REG: reg_addr/reg_data load, reg_valid = 1 in the cycle after the CHK strobe -> EXEC.
//   - EXEC: hold reg_valid, reg_addr, reg_data stable. On the cycle reg_valid & reg_ready: next cycle reg_valid = 0, cmd_done = 1 -> HUNT. No timeout in EXEC.
// - A SYNC_BYTE value outside HUNT is treated as ordinary data, with no resync.
// - Timeout:
//   - Counter clears on every frame_valid and on entry to CMD; it counts only in CMD/ARG1/ARG2/CHK.
//   - Reaching TIMEOUT_TICKS -> cmd_error, ERR_TIMEOUT (3'd3) -> HUNT.
//   - frame_valid in the expiry cycle wins: the byte is processed and the counter clears.
// - Overrun: frame_valid during EXEC -> frame dropped, cmd_error, ERR_OVERRUN (3'd4). The pending write continues and still completes with cmd_done.
// - Simultaneous reg_ready and overrun in EXEC: both effects occur; cmd_done and cmd_error may pulse in the same cycle.
// - All outputs are registered. Nothing changes combinationally from any input.
// STRUCTURE
// - uart_ctrl_defs.vh: state encodings, opcodes OP_WRITE_REG/OP_SET_CFG, ERR_* codes, cfg bit positions. Shared with the VGA register file and the test bench.
// - Sub-module uart_ctrl_timeout: ticks counter with clear, enable, and an expired flag, width $clog2(TIMEOUT_TICKS+1).
// - The top level holds the FSM, argument latches, config registers and handshake.
// TESTING
// 1. Valid write: A5 01 10 3C 2D, reg_ready tied 1 -> reg_valid for 1 cycle, addr=0x10, data=0x3C, then cmd_done.
// 2. Write with reg_ready low 20 cycles -> reg_valid and addr/data stable for all 20 cycles. A frame sent meanwhile -> ERR_OVERRUN, write still completes.
// 3. SET_CFG A5 02 87 00 85 -> parity=1, parity_type=1, stop_bits=1, frame_length=8, cmd_done. Then A5 02 40 00 42 (length 4) -> ERR_ARG, config unchanged.
// 4. Bad checksum A5 01 10 3C 00 -> ERR_CHK, reg_valid never rises. Unknown opcode A5 07 -> ERR_CMD after byte 2.
// 5. Garbage 00 FF then A5 01 10 3C 2D -> garbage ignored silently, write executes. A5 01 with a gap of 704 ticks -> ERR_TIMEOUT, state HUNT. A gap of 703 ticks -> no error.
// 6. Reset asserted in EXEC -> reg_valid=0, busy=0 and config = DEF_* immediately. The next packet is handled normally.

Source files
------------

// File: rtl/uart_cmd_controller_pkg.sv
// Shared definitions for the UART command controller: FSM states, opcodes,
// error codes, config bit positions and packet helpers.
package uart_cmd_controller_pkg;

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_CMD  = 3'd1,
    ST_ARG1 = 3'd2,
    ST_ARG2 = 3'd3,
    ST_CHK  = 3'd4,
    ST_EXEC = 3'd5
  } state_t;

  localparam logic [7:0] OP_WRITE_REG = 8'h01;
  localparam logic [7:0] OP_SET_CFG   = 8'h02;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CHK     = 3'd1;
  localparam logic [2:0] ERR_CMD     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;
  localparam logic [2:0] ERR_ARG     = 3'd5;

  // Field positions inside the SET_CFG argument byte
  localparam int CFG_PARITY_BIT = 0;
  localparam int CFG_PTYPE_BIT  = 1;
  localparam int CFG_STOP_BIT   = 2;
  localparam int CFG_LEN_LSB    = 4;
  localparam int CFG_LEN_MSB    = 7;

  function automatic logic [7:0] pkt_checksum(input logic [7:0] op,
                                              input logic [7:0] a1,
                                              input logic [7:0] a2);
    return op ^ a1 ^ a2;
  endfunction

  function automatic logic frame_len_ok(input logic [3:0] len);
    return (len == 4'd8) || (len == 4'd9);
  endfunction

endpackage

// File: rtl/uart_cmd_controller_if.sv
// Bundle between the UART frame processor / VGA register file side and the
// command controller; slave is the controller's view.
interface uart_cmd_controller_if;
  logic [8:0] frame;
  logic       frame_valid;
  logic       parity;
  logic       parity_type;
  logic       stop_bits;
  logic [3:0] frame_length;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic       reg_valid;
  logic       reg_ready;
  logic       cmd_done;
  logic       cmd_error;
  logic [2:0] err_code;
  logic       busy;

  modport slave (
    input  frame, frame_valid, reg_ready,
    output parity, parity_type, stop_bits, frame_length,
    output reg_addr, reg_data, reg_valid,
    output cmd_done, cmd_error, err_code, busy
  );

  modport master (
    output frame, frame_valid, reg_ready,
    input  parity, parity_type, stop_bits, frame_length,
    input  reg_addr, reg_data, reg_valid,
    input  cmd_done, cmd_error, err_code, busy
  );
endinterface

// File: rtl/uart_cmd_controller_timeout.sv
// Inter-frame gap counter: expired_o flags the cycle in which the
// TIMEOUT_TICKS-th consecutive enabled tick without a clear occurs.
module uart_cmd_controller_timeout #(
  parameter int TIMEOUT_TICKS = 704
) (
  input  logic clk_16bd,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_TICKS - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_16bd or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // cnt_q holds the number of idle ticks already elapsed, so this cycle is tick LAST+1
  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_controller.sv
// UART receive-path sequencer: assembles SYNC/CMD/ARG1/ARG2/CHK packets,
// owns the receiver configuration and issues VGA register writes.
module uart_cmd_controller
  import uart_cmd_controller_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE        = 8'hA5,
  parameter int         TIMEOUT_TICKS    = 704,
  parameter logic       DEF_PARITY       = 1'b0,
  parameter logic       DEF_PARITY_TYPE  = 1'b0,
  parameter logic       DEF_STOP_BITS    = 1'b0,
  parameter logic [3:0] DEF_FRAME_LENGTH = 4'd8
) (
  input  logic                  clk_16bd,
  input  logic                  rst,
  uart_cmd_controller_if.slave  bus
);

  state_t     state_q;
  logic [7:0] op_q, arg1_q, arg2_q;
  logic       parity_q, parity_type_q, stop_bits_q;
  logic [3:0] frame_length_q;
  logic [7:0] reg_addr_q, reg_data_q;
  logic       reg_valid_q, cmd_done_q, cmd_error_q, busy_q;
  logic [2:0] err_code_q;

  logic       fv;
  logic [7:0] rx_byte;
  logic       unused_frame_msb;
  logic       tmo_en, tmo_clr, tmo_expired;

  assign fv               = bus.frame_valid;
  assign rx_byte          = bus.frame[7:0];
  assign unused_frame_msb = bus.frame[8];

  assign tmo_en  = (state_q == ST_CMD) || (state_q == ST_ARG1) ||
                   (state_q == ST_ARG2) || (state_q == ST_CHK);
  assign tmo_clr = fv || !tmo_en;

  uart_cmd_controller_timeout #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timeout (
    .clk_16bd  (clk_16bd),
    .rst       (rst),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_expired)
  );

  always_ff @(posedge clk_16bd or posedge rst) begin
    if (rst) begin
      state_q        <= ST_HUNT;
      op_q           <= '0;
      arg1_q         <= '0;
      arg2_q         <= '0;
      parity_q       <= DEF_PARITY;
      parity_type_q  <= DEF_PARITY_TYPE;
      stop_bits_q    <= DEF_STOP_BITS;
      frame_length_q <= DEF_FRAME_LENGTH;
      reg_addr_q     <= '0;
      reg_data_q     <= '0;
      reg_valid_q    <= 1'b0;
      cmd_done_q     <= 1'b0;
      cmd_error_q    <= 1'b0;
      err_code_q     <= ERR_NONE;
      busy_q         <= 1'b0;
    end else begin
      cmd_done_q  <= 1'b0;
      cmd_error_q <= 1'b0;

      // A frame arriving in the expiry cycle takes precedence over the timeout
      if (tmo_expired && !fv) begin
        cmd_error_q <= 1'b1;
        err_code_q  <= ERR_TIMEOUT;
        state_q     <= ST_HUNT;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_HUNT: begin
            if (fv && (rx_byte == SYNC_BYTE)) begin
              state_q <= ST_CMD;
              busy_q  <= 1'b1;
            end
          end
          ST_CMD: begin
            if (fv) begin
              if ((rx_byte == OP_WRITE_REG) || (rx_byte == OP_SET_CFG)) begin
                op_q    <= rx_byte;
                state_q <= ST_ARG1;
              end else begin
                cmd_error_q <= 1'b1;
                err_code_q  <= ERR_CMD;
                state_q     <= ST_HUNT;
                busy_q      <= 1'b0;
              end
            end
          end
          ST_ARG1: begin
            if (fv) begin
              arg1_q  <= rx_byte;
              state_q <= ST_ARG2;
            end
          end
          ST_ARG2: begin
            if (fv) begin
              arg2_q  <= rx_byte;
              state_q <= ST_CHK;
            end
          end
          ST_CHK: begin
            if (fv) begin
              state_q <= ST_HUNT;
              busy_q  <= 1'b0;
              if (rx_byte != pkt_checksum(op_q, arg1_q, arg2_q)) begin
                cmd_error_q <= 1'b1;
                err_code_q  <= ERR_CHK;
              end else if (op_q == OP_SET_CFG) begin
                if (frame_len_ok(arg1_q[CFG_LEN_MSB:CFG_LEN_LSB])) begin
                  parity_q       <= arg1_q[CFG_PARITY_BIT];
                  parity_type_q  <= arg1_q[CFG_PTYPE_BIT];
                  stop_bits_q    <= arg1_q[CFG_STOP_BIT];
                  frame_length_q <= arg1_q[CFG_LEN_MSB:CFG_LEN_LSB];
                  cmd_done_q     <= 1'b1;
                end else begin
                  cmd_error_q <= 1'b1;
                  err_code_q  <= ERR_ARG;
                end
              end else begin
                reg_addr_q  <= arg1_q;
                reg_data_q  <= arg2_q;
                reg_valid_q <= 1'b1;
                state_q     <= ST_EXEC;
                busy_q      <= 1'b1;
              end
            end
          end
          ST_EXEC: begin
            if (reg_valid_q && bus.reg_ready) begin
              reg_valid_q <= 1'b0;
              cmd_done_q  <= 1'b1;
              state_q     <= ST_HUNT;
              busy_q      <= 1'b0;
            end
            // Overrun drops the byte but leaves the pending write untouched
            if (fv) begin
              cmd_error_q <= 1'b1;
              err_code_q  <= ERR_OVERRUN;
            end
          end
          default: begin
            state_q <= ST_HUNT;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.parity       = parity_q;
  assign bus.parity_type  = parity_type_q;
  assign bus.stop_bits    = stop_bits_q;
  assign bus.frame_length = frame_length_q;
  assign bus.reg_addr     = reg_addr_q;
  assign bus.reg_data     = reg_data_q;
  assign bus.reg_valid    = reg_valid_q;
  assign bus.cmd_done     = cmd_done_q;
  assign bus.cmd_error    = cmd_error_q;
  assign bus.err_code     = err_code_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Bench for uart_cmd_controller: packet-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_uart_cmd_controller;

  localparam int TMO = 704;

  logic clk_16bd = 1'b0;
  logic rst      = 1'b1;

  uart_cmd_controller_if bus();

  uart_cmd_controller dut (
    .clk_16bd (clk_16bd),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_16bd = ~clk_16bd;

  int vectors     = 0;
  int miscompares = 0;
  int fail_prints = 0;

  // Reference model: bytes collected since SYNC, idle counter, pending write
  logic [7:0] m_bytes[$];
  bit         m_in_pkt;
  bit         m_exec;
  int         m_idle;
  logic [7:0] m_b, m_a1;

  logic       e_par, e_pty, e_stop;
  logic [3:0] e_len;
  logic [7:0] e_addr, e_data;
  logic       e_valid, e_done, e_err, e_busy;
  logic [2:0] e_code;

  // Observations of DUT pulses
  int         n_done = 0;
  int         n_err  = 0;
  int         v_cycles = 0;
  int         last_code = 0;
  int         last_addr = 0;
  int         last_data = 0;

  logic [29:0] act_vec, exp_vec;

  task automatic model_reset();
    m_bytes.delete();
    m_in_pkt = 0;
    m_exec   = 0;
    m_idle   = 0;
    e_par = 0; e_pty = 0; e_stop = 0; e_len = 4'd8;
    e_addr = 0; e_data = 0;
    e_valid = 0; e_done = 0; e_err = 0; e_busy = 0; e_code = 0;
  endtask

  task automatic model_err(input logic [2:0] code);
    e_err  = 1;
    e_code = code;
  endtask

  // Advance the model by one clock using the inputs the next edge will sample
  task automatic model_step();
    m_b    = bus.frame[7:0];
    e_done = 0;
    e_err  = 0;
    if (m_exec) begin
      if (e_valid && bus.reg_ready) begin
        e_valid = 0;
        e_done  = 1;
        m_exec  = 0;
      end
      if (bus.frame_valid) model_err(3'd4);
    end else if (!m_in_pkt) begin
      if (bus.frame_valid && m_b == 8'hA5) begin
        m_in_pkt = 1;
        m_bytes.delete();
        m_idle = 0;
      end
    end else if (bus.frame_valid) begin
      m_idle = 0;
      m_bytes.push_back(m_b);
      if (m_bytes.size() == 1 && m_b != 8'h01 && m_b != 8'h02) begin
        model_err(3'd2);
        m_in_pkt = 0;
      end else if (m_bytes.size() == 4) begin
        m_in_pkt = 0;
        m_a1 = m_bytes[1];
        if ((m_bytes[0] ^ m_bytes[1] ^ m_bytes[2]) != m_bytes[3]) begin
          model_err(3'd1);
        end else if (m_bytes[0] == 8'h02) begin
          if (m_a1[7:4] == 4'd8 || m_a1[7:4] == 4'd9) begin
            e_par  = m_a1[0];
            e_pty  = m_a1[1];
            e_stop = m_a1[2];
            e_len  = m_a1[7:4];
            e_done = 1;
          end else begin
            model_err(3'd5);
          end
        end else begin
          e_addr  = m_bytes[1];
          e_data  = m_bytes[2];
          e_valid = 1;
          m_exec  = 1;
        end
      end
    end else begin
      m_idle++;
      if (m_idle >= TMO) begin
        model_err(3'd3);
        m_in_pkt = 0;
      end
    end
    e_busy = m_in_pkt || m_exec;
  endtask

  // Single compare process, away from the active edge
  always @(negedge clk_16bd) begin
    if (rst) model_reset();
    act_vec = {bus.parity, bus.parity_type, bus.stop_bits, bus.frame_length,
               bus.reg_addr, bus.reg_data, bus.reg_valid, bus.cmd_done,
               bus.cmd_error, bus.err_code, bus.busy};
    exp_vec = {e_par, e_pty, e_stop, e_len, e_addr, e_data, e_valid, e_done,
               e_err, e_code, e_busy};
    vectors++;
    if (act_vec !== exp_vec) begin
      miscompares++;
      if (fail_prints < 20) begin
        fail_prints++;
        $display("FAIL outputs t=%0t act=%h exp=%h", $time, act_vec, exp_vec);
      end
    end
    if (bus.cmd_done === 1'b1) n_done++;
    if (bus.cmd_error === 1'b1) begin
      n_err++;
      last_code = int'(bus.err_code);
    end
    if (bus.reg_valid === 1'b1) begin
      v_cycles++;
      last_addr = int'(bus.reg_addr);
      last_data = int'(bus.reg_data);
    end
    if (!rst) model_step();
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_16bd);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_gap(input logic [7:0] b, input int gap);
    bus.frame       = {1'($urandom_range(0, 1)), b};
    bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    idle(gap);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3,
                          input logic [7:0] b4);
    send_gap(b0, 2);
    send_gap(b1, 2);
    send_gap(b2, 2);
    send_gap(b3, 2);
    send_gap(b4, 2);
  endtask

  int d0, e0, v0;

  initial begin
    bus.frame       = '0;
    bus.frame_valid = 1'b0;
    bus.reg_ready   = 1'b0;
    rst             = 1'b1;
    repeat (3) @(posedge clk_16bd);
    #1 rst = 1'b0;

    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.reg_valid, 0);
    check("rst_len", bus.frame_length, 8);
    check("rst_code", bus.err_code, 0);

    // Valid write with ready tied high
    bus.reg_ready = 1'b1;
    d0 = n_done; v0 = v_cycles;
    send_pkt(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D);
    idle(4);
    check("t1_valid_cycles", v_cycles - v0, 1);
    check("t1_addr", last_addr, 8'h10);
    check("t1_data", last_data, 8'h3C);
    check("t1_done", n_done - d0, 1);

    // Stalled write with an overrun frame in the middle
    bus.reg_ready = 1'b0;
    d0 = n_done; e0 = n_err; v0 = v_cycles;
    send_pkt(8'hA5, 8'h01, 8'h22, 8'h5A, 8'h79);
    idle(5);
    send_gap(8'h55, 2);
    idle(13);
    check("t2_held", (v_cycles - v0) >= 20 ? 1 : 0, 1);
    check("t2_overrun_err", n_err - e0, 1);
    check("t2_overrun_code", last_code, 4);
    check("t2_no_done_yet", n_done - d0, 0);
    check("t2_addr", last_addr, 8'h22);
    check("t2_data", last_data, 8'h5A);
    bus.reg_ready = 1'b1;
    idle(4);
    check("t2_done", n_done - d0, 1);
    check("t2_valid_low", bus.reg_valid, 0);

    // SET_CFG valid, then illegal frame length
    d0 = n_done; e0 = n_err;
    send_pkt(8'hA5, 8'h02, 8'h87, 8'h00, 8'h85);
    idle(3);
    check("t3_parity", bus.parity, 1);
    check("t3_ptype", bus.parity_type, 1);
    check("t3_stop", bus.stop_bits, 1);
    check("t3_len", bus.frame_length, 8);
    check("t3_done", n_done - d0, 1);
    check("t3_model_len", int'(e_len), 8);
    check("t3_model_par", int'(e_par), 1);
    send_pkt(8'hA5, 8'h02, 8'h40, 8'h00, 8'h42);
    idle(3);
    check("t3_arg_err", n_err - e0, 1);
    check("t3_arg_code", last_code, 5);
    check("t3_len_kept", bus.frame_length, 8);
    check("t3_parity_kept", bus.parity, 1);

    // Bad checksum and unknown opcode
    v0 = v_cycles; e0 = n_err;
    send_pkt(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h00);
    idle(3);
    check("t4_chk_code", last_code, 1);
    check("t4_no_valid", v_cycles - v0, 0);
    send_gap(8'hA5, 2);
    send_gap(8'h07, 2);
    idle(2);
    check("t4_cmd_code", last_code, 2);
    check("t4_errs", n_err - e0, 2);
    check("t4_busy", bus.busy, 0);

    // Garbage before a packet is dropped silently
    d0 = n_done; e0 = n_err;
    send_gap(8'h00, 2);
    send_gap(8'hFF, 2);
    send_pkt(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D);
    idle(4);
    check("t5_no_err", n_err - e0, 0);
    check("t5_done", n_done - d0, 1);

    // Gap of TIMEOUT_TICKS idle ticks expires
    e0 = n_err;
    send_gap(8'hA5, 2);
    send_gap(8'h01, TMO);
    idle(2);
    check("t5_tmo_err", n_err - e0, 1);
    check("t5_tmo_code", last_code, 3);
    check("t5_tmo_busy", bus.busy, 0);

    // One tick short of expiry: packet completes normally
    d0 = n_done; e0 = n_err;
    send_gap(8'hA5, 2);
    send_gap(8'h01, TMO - 1);
    send_gap(8'h10, 2);
    send_gap(8'h3C, 2);
    send_gap(8'h2D, 2);
    idle(4);
    check("t5_703_no_err", n_err - e0, 0);
    check("t5_703_done", n_done - d0, 1);

    // Asynchronous reset in EXEC
    bus.reg_ready = 1'b0;
    send_pkt(8'hA5, 8'h01, 8'h33, 8'h44, 8'h76);
    idle(3);
    check("t6_pre_valid", bus.reg_valid, 1);
    check("t6_pre_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_valid", bus.reg_valid, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_parity", bus.parity, 0);
    check("t6_ptype", bus.parity_type, 0);
    check("t6_stop", bus.stop_bits, 0);
    check("t6_len", bus.frame_length, 8);
    @(posedge clk_16bd);
    #1 rst = 1'b0;
    bus.reg_ready = 1'b1;
    d0 = n_done;
    send_pkt(8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D);
    idle(4);
    check("t6_after_done", n_done - d0, 1);
    check("t6_after_addr", last_addr, 8'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
